// File: rtl/sal_req_router_pkg.sv
// sal_router_pkg: shared slot type, width limits and address split helpers (SAL_ROUTER_BANK_HASH_EN selects hashed bank)
package sal_router_pkg;
    localparam int DEF_BK_CNT       = 16;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_ID_W         = 4;
    localparam int DEF_LEN_W        = 8;
    localparam int DEF_OFS_W        = 3;
    localparam int DEF_CA_W         = 10;
    localparam int DEF_RA_W         = 16;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int MAX_ID_W  = 16;
    localparam int MAX_LEN_W = 16;
    localparam int MAX_BA_W  = 16;
    localparam int MAX_RA_W  = 32;
    localparam int MAX_CA_W  = 32;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_LEN_W-1:0] len;
        logic [MAX_BA_W-1:0]  ba;
        logic [MAX_RA_W-1:0]  ra;
        logic [MAX_CA_W-1:0]  ca;
    } req_slot_t;

    function automatic logic [31:0] field(input logic [63:0] a, input int lsb, input int w);
        return 32'((a >> lsb) & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [31:0] get_ca(input logic [63:0] a, input int ofs, input int caw);
        return field(a, ofs, caw);
    endfunction

    function automatic logic [31:0] get_ra(input logic [63:0] a, input int ofs, input int caw, input int baw, input int raw);
        return field(a, ofs + caw + baw, raw);
    endfunction

    function automatic logic [31:0] get_ba(input logic [63:0] a, input int ofs, input int caw, input int baw, input int raw);
        logic [31:0] b;
        b = field(a, ofs + caw, baw);
`ifdef SAL_ROUTER_BANK_HASH_EN
        b = b ^ (get_ra(a, ofs, caw, baw, raw) & ((32'd1 << baw) - 32'd1));
`endif
        return b;
    endfunction

    function automatic req_slot_t mk_slot(input logic wr, input logic [MAX_ID_W-1:0] id, input logic [MAX_LEN_W-1:0] len,
                                          input logic [63:0] a, input int ofs, input int caw, input int baw, input int raw);
        req_slot_t s;
        s.valid = 1'b1;
        s.wr    = wr;
        s.id    = id;
        s.len   = len;
        s.ba    = MAX_BA_W'(get_ba(a, ofs, caw, baw, raw));
        s.ra    = get_ra(a, ofs, caw, baw, raw);
        s.ca    = get_ca(a, ofs, caw);
        return s;
    endfunction
endpackage

// File: rtl/sal_req_router_if.sv
// sal_req_router_if: AXI AW/AR address channels plus packed per-bank request ports
interface sal_req_router_if #(
    parameter int BK_CNT = 16,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8,
    parameter int RA_W   = 16,
    parameter int CA_W   = 10
);
    logic                    awvalid, awready;
    logic [ID_W-1:0]         awid;
    logic [ADDR_W-1:0]       awaddr;
    logic [LEN_W-1:0]        awlen;
    logic                    arvalid, arready;
    logic [ID_W-1:0]         arid;
    logic [ADDR_W-1:0]       araddr;
    logic [LEN_W-1:0]        arlen;
    logic [BK_CNT-1:0]       req_valid, req_ready, req_wr;
    logic [BK_CNT*ID_W-1:0]  req_id;
    logic [BK_CNT*LEN_W-1:0] req_len;
    logic [BK_CNT*RA_W-1:0]  req_ra;
    logic [BK_CNT*CA_W-1:0]  req_ca;

    modport master(output awvalid, awid, awaddr, awlen, arvalid, arid, araddr, arlen, req_ready,
                   input awready, arready, req_valid, req_wr, req_id, req_len, req_ra, req_ca);
    modport slave(input awvalid, awid, awaddr, awlen, arvalid, arid, araddr, arlen, req_ready,
                  output awready, arready, req_valid, req_wr, req_id, req_len, req_ra, req_ca);
endinterface

// File: rtl/sal_req_slot.sv
// sal_req_slot: one-entry request holding register; load beats clear, clear drops valid
module sal_req_slot
    import sal_router_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      clr,
    input  req_slot_t d,
    output req_slot_t q
);
    // load replaces the entry even while it dispatches, so back-to-back beats need no bubble
    always_ff @(posedge clk)
        if (!rst_n) q <= '0;
        else if (load) q <= d;
        else if (clr) q.valid <= 1'b0;
endmodule

// File: rtl/sal_req_router.sv
// sal_req_router: AW/AR slot capture, bank decode and write-priority dispatch with read starvation bound (SAL_ROUTER_BANK_HASH_EN: hashed bank)
module sal_req_router
    import sal_router_pkg::*;
#(
    parameter int BK_CNT       = DEF_BK_CNT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ID_W         = DEF_ID_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int OFS_W        = DEF_OFS_W,
    parameter int CA_W         = DEF_CA_W,
    parameter int RA_W         = DEF_RA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic clk,
    input logic rst_n,
    sal_req_router_if.slave bus
);
    localparam int BA_W = $clog2(BK_CNT);
    localparam int SW   = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    req_slot_t       aw_d, ar_d, aw_q, ar_q;
    logic [BA_W-1:0] aw_ba, ar_ba;
    logic            conflict, ar_wins, aw_gnt, ar_gnt, aw_disp, ar_disp;
    logic [SW-1:0]   starve_cnt;
    logic            unused_slot;

    assign aw_d = mk_slot(1'b1, MAX_ID_W'(bus.awid), MAX_LEN_W'(bus.awlen), 64'(bus.awaddr), OFS_W, CA_W, BA_W, RA_W);
    assign ar_d = mk_slot(1'b0, MAX_ID_W'(bus.arid), MAX_LEN_W'(bus.arlen), 64'(bus.araddr), OFS_W, CA_W, BA_W, RA_W);

    sal_req_slot u_aw (.clk(clk), .rst_n(rst_n), .load(bus.awvalid & bus.awready), .clr(aw_disp), .d(aw_d), .q(aw_q));
    sal_req_slot u_ar (.clk(clk), .rst_n(rst_n), .load(bus.arvalid & bus.arready), .clr(ar_disp), .d(ar_d), .q(ar_q));

    assign aw_ba       = aw_q.ba[BA_W-1:0];
    assign ar_ba       = ar_q.ba[BA_W-1:0];
    assign conflict    = aw_q.valid & ar_q.valid & (aw_ba == ar_ba);
    assign ar_wins     = conflict & (starve_cnt >= LIM);
    assign aw_gnt      = aw_q.valid & ~ar_wins;
    assign ar_gnt      = ar_q.valid & (~conflict | ar_wins);
    assign aw_disp     = aw_gnt & bus.req_ready[aw_ba];
    assign ar_disp     = ar_gnt & bus.req_ready[ar_ba];
    assign bus.awready = ~aw_q.valid | aw_disp;
    assign bus.arready = ~ar_q.valid | ar_disp;
    assign unused_slot = ^{aw_q, ar_q};

    // count accepted conflicts the read lost; the read winning caps it at LIM, any read dispatch clears it
    always_ff @(posedge clk)
        if (!rst_n) starve_cnt <= '0;
        else if (ar_disp) starve_cnt <= '0;
        else if (conflict & ~ar_wins & bus.req_ready[aw_ba]) starve_cnt <= starve_cnt + 1'b1;

    // route granted slots onto their bank lanes; idle lanes stay all-zero
    always_comb begin
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_id    = '0;
        bus.req_len   = '0;
        bus.req_ra    = '0;
        bus.req_ca    = '0;
        if (aw_gnt) begin
            bus.req_valid[aw_ba]             = 1'b1;
            bus.req_wr[aw_ba]                = 1'b1;
            bus.req_id[aw_ba*ID_W +: ID_W]   = aw_q.id[ID_W-1:0];
            bus.req_len[aw_ba*LEN_W +: LEN_W] = aw_q.len[LEN_W-1:0];
            bus.req_ra[aw_ba*RA_W +: RA_W]   = aw_q.ra[RA_W-1:0];
            bus.req_ca[aw_ba*CA_W +: CA_W]   = aw_q.ca[CA_W-1:0];
        end
        if (ar_gnt) begin
            bus.req_valid[ar_ba]             = 1'b1;
            bus.req_id[ar_ba*ID_W +: ID_W]   = ar_q.id[ID_W-1:0];
            bus.req_len[ar_ba*LEN_W +: LEN_W] = ar_q.len[LEN_W-1:0];
            bus.req_ra[ar_ba*RA_W +: RA_W]   = ar_q.ra[RA_W-1:0];
            bus.req_ca[ar_ba*CA_W +: CA_W]   = ar_q.ca[CA_W-1:0];
        end
    end
endmodule

// File: tb/tb_sal_req_router.sv
// tb_sal_req_router: directed stimulus with per-channel expected-request queues checked by a dispatch monitor
module tb_sal_req_router;
    // a 9-bit column makes offset+column+bank+row tile the 32-bit address exactly
    localparam int CA_W = 9;

    typedef struct packed {
        logic [3:0]  bk;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [15:0] ra;
        logic [8:0]  ca;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t awq[$], arq[$];
    exp_t e_aw, e_ar;
    int   n_cmp = 0, n_bad = 0, n_wr = 0, n_rd = 0;
    logic aw_acc, ar_acc;

    sal_req_router_if #(.BK_CNT(16), .ADDR_W(32), .ID_W(4), .LEN_W(8), .RA_W(16), .CA_W(CA_W)) bus ();

    sal_req_router #(.BK_CNT(16), .ADDR_W(32), .ID_W(4), .LEN_W(8), .OFS_W(3), .CA_W(CA_W), .RA_W(16), .STARVE_LIMIT(8))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [3:0] bk, input logic [15:0] ra, input logic [8:0] ca);
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        bus.awid    = id;
        bus.awlen   = len;
        e_aw        = '{bk, id, len, ra, ca};
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [3:0] bk, input logic [15:0] ra, input logic [8:0] ca);
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        bus.arid    = id;
        bus.arlen   = len;
        e_ar        = '{bk, id, len, ra, ca};
    endtask

    task automatic step();
        @(negedge clk);
        aw_acc = rst_n && bus.awvalid && bus.awready;
        ar_acc = rst_n && bus.arvalid && bus.arready;
        if (aw_acc) awq.push_back(e_aw);
        if (ar_acc) arq.push_back(e_ar);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic zero_ok;
            exp_t got, e;
            zero_ok = 1'b1;
            for (int b = 0; b < 16; b++) begin
                got = '{4'(b), bus.req_id[b*4 +: 4], bus.req_len[b*8 +: 8], bus.req_ra[b*16 +: 16], bus.req_ca[b*CA_W +: CA_W]};
                if (bus.req_valid[b] && bus.req_ready[b]) begin
                    if (bus.req_wr[b]) begin
                        n_wr++;
                        if (awq.size() == 0) chk("aw_unexpected", 64'(got), 64'(0));
                        else begin
                            e = awq.pop_front();
                            chk("aw_dispatch", 64'(got), 64'(e));
                        end
                    end else begin
                        n_rd++;
                        if (arq.size() == 0) chk("ar_unexpected", 64'(got), 64'(0));
                        else begin
                            e = arq.pop_front();
                            chk("ar_dispatch", 64'(got), 64'(e));
                        end
                    end
                end else if (!bus.req_valid[b]) begin
                    zero_ok &= (bus.req_wr[b] === 1'b0) && (got[36:0] === '0);
                end
            end
            chk("idle_lanes_zero", 64'(zero_ok), 64'(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, mark, rd0;
        logic [3:0] hb;
        rst_n = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 32'h1048; bus.awid = 4'd1; bus.awlen = 8'd0;
        bus.arvalid = 1'b0; bus.araddr = 32'h0; bus.arid = 4'd0; bus.arlen = 8'd0;
        bus.req_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.req_valid), 64'(0));
        chk("rst_fields", 64'({bus.req_wr, |bus.req_id, |bus.req_len, |bus.req_ra, |bus.req_ca}), 64'(0));
        chk("rst_awready", 64'(bus.awready), 64'(1));
        chk("rst_arready", 64'(bus.arready), 64'(1));
        rst_n = 1'b1;
        bus.awvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(bus.req_valid), 64'(0));
        chk("post_rst_awready", 64'(bus.awready), 64'(1));

        set_aw(32'h0000_1048, 4'd1, 8'd3, 4'd1, 16'd0, 9'd9);
        set_ar(32'h0000_2088, 4'd2, 8'd7, 4'd2, 16'd0, 9'd17);
        step();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        chk("par_valid", 64'(bus.req_valid), 64'h0006);
        chk("par_wr", 64'(bus.req_wr), 64'h0002);
        step();
        chk("par_done", 64'(bus.req_valid), 64'(0));

        bus.req_ready = 16'hFFF7;
        set_aw(32'h0010_3010, 4'd3, 8'd1, 4'd3, 16'h10, 9'd2);
        set_ar(32'h0020_4028, 4'd4, 8'd2, 4'd4, 16'h20, 9'd5);
        step();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        rd0 = n_rd;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 64'(bus.req_valid[3]), 64'(1));
            chk("stall_ra", 64'(bus.req_ra[48 +: 16]), 64'h10);
            chk("stall_ca", 64'(bus.req_ca[27 +: 9]), 64'(2));
            chk("stall_awready", 64'(bus.awready), 64'(0));
            step();
        end
        chk("stall_ar_count", 64'(n_rd - rd0), 64'(1));
        bus.req_ready = '1;
        step();
        chk("stall_done", 64'(bus.req_valid), 64'(0));

        k = 0;
        set_aw(32'h5000, 4'd5, 8'd0, 4'd5, 16'd0, 9'd0);
        set_ar(32'h5100, 4'd6, 8'd0, 4'd5, 16'd0, 9'd32);
        for (int r = 0; r < 2; r++) begin
            ar_acc = 1'b0;
            for (int t = 0; t < 5 && !ar_acc; t++) begin
                step();
                if (aw_acc) begin k++; set_aw(32'h5000 + 32'(k << 3), 4'd5, 8'd0, 4'd5, 16'd0, 9'(k)); end
                if (ar_acc) bus.arvalid = 1'b0;
            end
            mark = n_wr;
            rd0 = n_rd;
            for (int t = 0; t < 30 && n_rd == rd0; t++) begin
                step();
                if (aw_acc) begin k++; set_aw(32'h5000 + 32'(k << 3), 4'd5, 8'd0, 4'd5, 16'd0, 9'(k)); end
            end
            chk("starve_ar_dispatched", 64'(n_rd - rd0), 64'(1));
            chk("starve_aw_wins", 64'(n_wr - mark), 64'(8));
            set_ar(32'h5108, 4'd7, 8'd0, 4'd5, 16'd0, 9'd33);
        end
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        repeat (2) step();

        rd0 = n_rd;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_arready", 64'(bus.arready), 64'(1));
            set_ar(32'h6000 + 32'(i * 8), 4'(i), 8'(i), 4'd6, 16'd0, 9'(i));
            step();
            chk("b2b_valid", 64'(bus.req_valid[6]), 64'(1));
        end
        bus.arvalid = 1'b0;
        step();
        chk("b2b_count", 64'(n_rd - rd0), 64'(6));

`ifdef SAL_ROUTER_BANK_HASH_EN
        hb = 4'd5;
`else
        hb = 4'd2;
`endif
        set_aw(32'h0007_2000, 4'd9, 8'd5, hb, 16'h7, 9'd0);
        step();
        bus.awvalid = 1'b0;
        chk("hash_valid", 64'(bus.req_valid), 64'(16'd1 << hb));
        repeat (2) step();

        chk("awq_drained", 64'(awq.size()), 64'(0));
        chk("arq_drained", 64'(arq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sal_req_router.md
# sal_req_router

Parametrised, registered successor to the single-issue AXI-to-bank address decoder. Captures AW and AR address beats into one-entry slots, decodes them into bank/row/column, and dispatches to per-bank request ports. A write and a read targeting different banks dispatch in the same cycle. Same-bank conflicts use write priority with a bounded read-starvation counter. Sits between the AXI slave front end and the bank controllers.

## Interface
Parameters:
- BK_CNT, 16: number of banks; power of two, ≥2
- ADDR_W, 32: AXI address width
- ID_W, 4 / LEN_W, 8: AXI id and len widths
- OFS_W, 3: low byte-offset bits, dropped
- CA_W, 10 / RA_W, 16: column and row widths; BA_W = $clog2(BK_CNT) is derived
- STARVE_LIMIT, 8: consecutive lost same-bank conflicts before a read wins; 0 means a read always wins a conflict

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- awvalid / awready  in / out  1  AW handshake
- awid, awaddr, awlen  in  ID_W, ADDR_W, LEN_W  AW fields
- arvalid / arready  in / out  1  AR handshake
- arid, araddr, arlen  in  ID_W, ADDR_W, LEN_W  AR fields
- req_valid  out  BK_CNT  per-bank request valid
- req_ready  in  BK_CNT  per-bank accept
- req_wr  out  BK_CNT  1 = write
- req_id, req_len, req_ra, req_ca  out  BK_CNT×ID_W, ×LEN_W, ×RA_W, ×CA_W  per-bank fields; packed, bank b at slice b

## Operation
- Address split: ca = addr[OFS_W +: CA_W]; ba = next BA_W bits; ra = next RA_W bits; remaining upper bits ignored.
- Each channel has one slot: valid, id, len, ba, ra, ca.
  - Slot loads on a valid&ready handshake.
  - Slot clears on dispatch, unless a new beat loads in the same cycle.
- Dispatch for AW slot to bank b: slot valid, slot ba==b, req_ready[b]=1, and AW wins b. AR uses the same rule.
- Different banks: both slots dispatch in the same cycle.
- Same bank (conflict):
  - AW wins unless starve_cnt ≥ STARVE_LIMIT, in which case AR wins.
  - The loser holds its slot.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - +1, saturating, on each conflict cycle with req_ready[b]=1 where AW wins.
  - Cleared whenever the AR slot dispatches.
  - Unchanged on conflict cycles with req_ready[b]=0.
- req_valid[b] = 1 when a granted slot targets b. req_ready does not gate req_valid; valid is held until accepted.
- A non-valid bank drives req_wr and all its fields to 0 (never X).
- awready = !aw_slot_valid | aw_dispatch. arready follows the same rule. Both are combinational from req_ready.

## Timing
- Reset (rst_n low at a clock edge): both slots empty, starve_cnt=0. On the next cycle: req_valid=0, all req fields 0, awready=arready=1.
- Reset mid-operation drops held slots without dispatch.
- Latency: AXI handshake in cycle N → req_valid in cycle N+1 → dispatch in the first cycle with req_ready high.
- Throughput: one beat per channel per cycle when banks are ready.
- Simultaneous load and dispatch on one slot: the new beat replaces the old with no bubble.
- Stalled bank: slot held and its ready deasserted. The other channel is unaffected if it targets a different bank.
- The arbitration decision is taken on the current starve_cnt value; the updated count applies from the next cycle.

## Configuration
- SAL_ROUTER_BANK_HASH_EN defined: ba = addr bank field XOR ra[BA_W-1:0]. This spreads row-strided traffic. ra and ca are unchanged.
- Not defined: ba is the plain address bank field.

## Structure
- Package sal_router_pkg holds:
  - req_slot_t struct: valid, wr, id, len, ba, ra, ca
  - get_ba/get_ra/get_ca functions, including the hash variant
  - default width constants
- Sub-module sal_req_slot: one-entry holding register with load/clear/hold. Instantiated once for AW and once for AR.
- Arbitration and starve counter live in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 clocks while awvalid=1 → req_valid=0, fields 0. The cycle after release: awready=1, no dispatch.
- AW addr 0x0000_1048 and AR addr 0x0000_2088 in the same cycle, all banks ready, no hash → next cycle req_valid has bits 1 and 2 set together. Bank 1: req_wr=1, ca=9. Bank 2: req_wr=0, ca=17.
- Both slots target bank 5 continuously, STARVE_LIMIT=8, AW refilled every cycle → AW dispatches 8 consecutive cycles, then AR dispatches on cycle 9 and starve_cnt returns to 0.
- AW to bank 3 with req_ready[3]=0 for 4 cycles → req_valid[3] held with stable fields and awready=0. Meanwhile AR to bank 4 dispatches normally.
- Back-to-back AR beats every cycle with bank ready → arready stays 1 and one dispatch per cycle with no bubbles.
- With SAL_ROUTER_BANK_HASH_EN, addr bank field 2 and ra=0x0007 → request appears on bank 5.
